// File: rtl/fpu_addsub_sched_pkg.sv
// Shared constants and types for the FP add/sub scheduler.
// Op encoding, requester IDs, latency ceiling and the in-flight tag type.
package fpu_addsub_sched_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int unsigned LATENCY_MAX = 8;

   // One slot of the ownership pipe that runs alongside the datapath.
   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter with per-requester eligibility.
// Ports: clk, reset (sync, active-low), valid[1:0], elig[1:0] in;
//        grant_c[1:0] out (combinational, one-hot or zero).
module fpu_rr_arb2
   import fpu_addsub_sched_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic [1:0] elig,
   output logic [1:0] grant_c
);

   logic last_q;
   logic last_d;
   logic [1:0] req;

   // Grant selection; a tie goes to whoever was not granted last.
   always_comb begin
      req     = valid & elig;
      grant_c = 2'b00;
      last_d  = last_q;
      if (req == 2'b11) begin
         grant_c = (last_q == REQ1) ? 2'b01 : 2'b10;
      end else begin
         grant_c = req;
      end
      if (grant_c[0]) begin
         last_d = REQ0;
      end else if (grant_c[1]) begin
         last_d = REQ1;
      end
   end

   // Pointer starts as "requester 1 granted last" so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_q <= REQ1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Shares one pipelined FP add/sub datapath between two requesters.
// Ports: clk, reset (sync, active-low);
//        reqN_valid/a/b/op in, reqN_ready out (combinational grant);
//        dp_valid/dp_a/dp_b/dp_op out, dp_result in (LATENCY after dp_valid);
//        respN_valid/respN_data out; busy out.
module fpu_addsub_sched
   import fpu_addsub_sched_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 3,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_op,
   output logic             dp_valid,
   output logic [WIDTH-1:0] dp_a,
   output logic [WIDTH-1:0] dp_b,
   output logic             dp_op,
   input  logic [WIDTH-1:0] dp_result,
   output logic             resp0_valid,
   output logic [WIDTH-1:0] resp0_data,
   output logic             resp1_valid,
   output logic [WIDTH-1:0] resp1_data,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   logic [1:0]       grant_c;
   logic [1:0]       elig;

   logic             dp_valid_q, dp_valid_d;
   logic [WIDTH-1:0] dp_a_q, dp_a_d;
   logic [WIDTH-1:0] dp_b_q, dp_b_d;
   logic             dp_op_q, dp_op_d;
   logic             dp_owner_q, dp_owner_d;

   tag_t             tag_q [LATENCY];
   tag_t             tag_d [LATENCY];
   tag_t             tag_out;
   logic             tag_any_d;

   logic             resp0_valid_q, resp0_valid_d;
   logic             resp1_valid_q, resp1_valid_d;
   logic [WIDTH-1:0] resp0_data_q, resp0_data_d;
   logic [WIDTH-1:0] resp1_data_q, resp1_data_d;

   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             busy_q, busy_d;

   // A response leaving this cycle frees its slot for an issue in the same cycle.
   assign elig[0] = (cnt0_q < CNT_W'(MAX_OUT)) | resp0_valid_q;
   assign elig[1] = (cnt1_q < CNT_W'(MAX_OUT)) | resp1_valid_q;

   fpu_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .valid   ({req1_valid, req0_valid}),
      .elig    (elig),
      .grant_c (grant_c)
   );

   assign req0_ready = grant_c[0];
   assign req1_ready = grant_c[1];

   // Issue register, ownership pipe, response steering, counters, busy.
   always_comb begin
      dp_valid_d = |grant_c;
      dp_a_d     = dp_a_q;
      dp_b_d     = dp_b_q;
      dp_op_d    = dp_op_q;
      dp_owner_d = dp_owner_q;
      if (grant_c[0]) begin
         dp_a_d     = req0_a;
         dp_b_d     = req0_b;
         dp_op_d    = req0_op;
         dp_owner_d = REQ0;
      end else if (grant_c[1]) begin
         dp_a_d     = req1_a;
         dp_b_d     = req1_b;
         dp_op_d    = req1_op;
         dp_owner_d = REQ1;
      end

      tag_d[0].valid = dp_valid_q;
      tag_d[0].owner = dp_owner_q;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      tag_any_d = 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         tag_any_d = tag_any_d | tag_d[i].valid;
      end

      // The last tag stage lines up with dp_result for the op it describes.
      tag_out       = tag_q[LATENCY-1];
      resp0_valid_d = tag_out.valid & (tag_out.owner == REQ0);
      resp1_valid_d = tag_out.valid & (tag_out.owner == REQ1);
      resp0_data_d  = resp0_valid_d ? dp_result : resp0_data_q;
      resp1_data_d  = resp1_valid_d ? dp_result : resp1_data_q;

      cnt0_d = cnt0_q;
      case ({grant_c[0], resp0_valid_q})
         2'b10:   cnt0_d = cnt0_q + CNT_W'(1);
         2'b01:   cnt0_d = cnt0_q - CNT_W'(1);
         default: cnt0_d = cnt0_q;
      endcase
      cnt1_d = cnt1_q;
      case ({grant_c[1], resp1_valid_q})
         2'b10:   cnt1_d = cnt1_q + CNT_W'(1);
         2'b01:   cnt1_d = cnt1_q - CNT_W'(1);
         default: cnt1_d = cnt1_q;
      endcase

      busy_d = dp_valid_d | tag_any_d | resp0_valid_d | resp1_valid_d;
   end

   // Reset drops everything in flight; no responses are produced for it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dp_valid_q    <= 1'b0;
         dp_a_q        <= '0;
         dp_b_q        <= '0;
         dp_op_q       <= 1'b0;
         dp_owner_q    <= REQ0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
         end
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_data_q  <= '0;
         resp1_data_q  <= '0;
         cnt0_q        <= '0;
         cnt1_q        <= '0;
         busy_q        <= 1'b0;
      end else begin
         dp_valid_q    <= dp_valid_d;
         dp_a_q        <= dp_a_d;
         dp_b_q        <= dp_b_d;
         dp_op_q       <= dp_op_d;
         dp_owner_q    <= dp_owner_d;
         tag_q         <= tag_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp0_data_q  <= resp0_data_d;
         resp1_data_q  <= resp1_data_d;
         cnt0_q        <= cnt0_d;
         cnt1_q        <= cnt1_d;
         busy_q        <= busy_d;
      end
   end

   assign dp_valid    = dp_valid_q;
   assign dp_a        = dp_a_q;
   assign dp_b        = dp_b_q;
   assign dp_op       = dp_op_q;
   assign resp0_valid = resp0_valid_q;
   assign resp0_data  = resp0_data_q;
   assign resp1_valid = resp1_valid_q;
   assign resp1_data  = resp1_data_q;
   assign busy        = busy_q;

   // A response always has a matching outstanding issue; the cap is never exceeded.
   a_cnt0_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      resp0_valid_q |-> (cnt0_q != '0));
   a_cnt1_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      resp1_valid_q |-> (cnt1_q != '0));
   a_cnt0_cap: assert property (@(posedge clk) disable iff (!reset)
      cnt0_q <= CNT_W'(MAX_OUT));
   a_cnt1_cap: assert property (@(posedge clk) disable iff (!reset)
      cnt1_q <= CNT_W'(MAX_OUT));

endmodule
